sccb_init_sequencer: RTL and testbench
======================================

// Module: sccb_init_sequencer
// PURPOSE
//  Walks a camera register table and drives CoreSCCB (start/rw/sub_addr/data_in, done/data_out) to configure the sensor.
//  Each table entry is a write; optional read-back verify and inline delay entries. Sits between the init ROM and CoreSCCB.
//  Runs on system clk; sccb_done is 2-flop synchronised internally.
// PARAMETERS
//  TBL_AW        6         table address width; table depth = 2**TBL_AW entries
//  DEV_ADDR      7'h21     7-bit SCCB device address driven on sccb_ip_addr
//  CYC_PER_MS    50000     clk cycles per millisecond, for delay entries
//  TIMEOUT_CYC   2000000   max clk cycles waiting on any sccb_done edge before abort
// PORTS
//  clk           in   1        system clock
//  resetn        in   1        synchronous, active-low reset
//  go            in   1        1-cycle pulse: start sequence from entry 0 (ignored while busy)
//  verify_en     in   1        sampled at go; 1 = read back and compare every written entry
//  tbl_addr      out  TBL_AW   table read address
//  tbl_data      in   16       {sub_addr[15:8], data[7:0]}, valid 1 cycle after tbl_addr
//  sccb_start    out  1        level request to CoreSCCB; held until sccb_done seen high
//  sccb_rw       out  1        0 = 3-phase write, 1 = 2-phase write + read
//  sccb_ip_addr  out  7        = DEV_ADDR
//  sccb_sub_addr out  8        register address of current transaction
//  sccb_data_in  out  8        write data of current transaction
//  sccb_data_out in   8        read data from CoreSCCB, valid when sccb_done high
//  sccb_done     in   1        CoreSCCB done (async to clk, synchronised)
//  busy          out  1        high from go accepted until FINISH/ABORT
//  seq_done      out  1        1-cycle pulse when sequence ends (normal or abort)
//  error         out  1        sticky: verify mismatch or timeout; cleared on next accepted go
//  err_count     out  8        verify mismatches this run, saturates at 255
//  timeout       out  1        sticky: run aborted on timeout; cleared on next accepted go
//  cur_index     out  TBL_AW   index of entry being processed
// BEHAVIOUR
//  Reset: all outputs 0, tbl_addr 0, state IDLE; sccb_start drops on the reset cycle even mid-transaction.
//  Table codes: sub_addr 8'hFF & data 8'hFF = END; sub_addr 8'hFE = DELAY of data ms (0 = no delay); all else = WRITE.
//  FSM:
//   IDLE     : go -> clear error/err_count/timeout, index=0, latch verify_en, busy=1 -> FETCH.
//   FETCH    : tbl_addr=index; 1 wait cycle -> DECODE.
//   DECODE   : END -> FINISH; DELAY -> DLY (load data*CYC_PER_MS); WRITE -> latch sub/data, rw=0 -> REQ.
//   REQ      : sccb_start=1; wait synced done=1 -> ACK (verify: capture sccb_data_out if rw=1).
//   ACK      : sccb_start=0; wait synced done=0 -> if rw=0 & verify -> rw=1, REQ; if rw=1 -> CHECK; else NEXT.
//   CHECK    : captured != written data -> err_count+1 (sat), error=1; -> NEXT (no retry).
//   DLY      : count down to 0 -> NEXT.
//   NEXT     : index == 2**TBL_AW-1 -> FINISH (no wrap), else index+1 -> FETCH.
//   FINISH   : seq_done pulse, busy=0 -> IDLE.
//  Timeout counter resets on entry to REQ/ACK; reaching TIMEOUT_CYC -> sccb_start=0, error=timeout=1, seq_done pulse, IDLE.
//  sccb_sub_addr/data_in/rw stable for the whole time sccb_start is high; change only while start low.
//  go during busy: ignored, no effect on state or flags.
//  cur_index = index register; holds last value after FINISH.
// TESTING
//  Table {12:80, 11:01, FF:FF}, verify=0, done model echoes -> two writes (rw=0) then seq_done; error=0, cur_index=2.
//  Same table, verify=1, model returns 0x80 then 0x00 -> 4 transactions (W,R,W,R); err_count=1, error=1.
//  Entry FE:02 with CYC_PER_MS=10 -> sccb_start low for >=20 clk between neighbouring transactions.
//  Model never asserts done, TIMEOUT_CYC=100 -> start drops at cycle 100, timeout=1, seq_done pulse, busy=0.
//  resetn low mid-REQ -> next clk sccb_start=0, busy=0, all flags 0; new go runs from entry 0.
//  Table with no END, TBL_AW=2 -> exactly 4 writes, FINISH, no wrap; go during busy ignored.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
// Camera init sequencer: walks a {sub_addr, data} register table and drives CoreSCCB
// writes, with optional read-back verify, inline millisecond delays and a done timeout.
module sccb_init_sequencer #(
    parameter int         TBL_AW      = 6,
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         CYC_PER_MS  = 50000,
    parameter int         TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              go,
    input  logic              verify_en,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              sccb_start,
    output logic              sccb_rw,
    output logic [6:0]        sccb_ip_addr,
    output logic [7:0]        sccb_sub_addr,
    output logic [7:0]        sccb_data_in,
    input  logic [7:0]        sccb_data_out,
    input  logic              sccb_done,
    output logic              busy,
    output logic              seq_done,
    output logic              error,
    output logic [7:0]        err_count,
    output logic              timeout,
    output logic [TBL_AW-1:0] cur_index
);

    localparam int DLY_W = $clog2(255 * CYC_PER_MS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TBL_AW-1:0] LAST_IDX = {TBL_AW{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_REQ, S_ACK, S_CHECK, S_DLY, S_NEXT, S_FINISH
    } state_t;

    state_t           state;
    logic             verify_q;
    logic [7:0]       rd_data;
    logic [DLY_W-1:0] dly_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             done_p0, done_p1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign sccb_ip_addr = DEV_ADDR;

    // Stage p0/p1: two-flop synchroniser for the asynchronous CoreSCCB done
    always_ff @(posedge clk) begin
        if (!resetn) begin
            done_p0 <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            done_p0 <= sccb_done;
            done_p1 <= done_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            cur_index     <= '0;
            tbl_addr      <= '0;
            sccb_start    <= 1'b0;
            sccb_rw       <= 1'b0;
            sccb_sub_addr <= 8'h00;
            sccb_data_in  <= 8'h00;
            busy          <= 1'b0;
            seq_done      <= 1'b0;
            error         <= 1'b0;
            err_count     <= 8'h00;
            timeout       <= 1'b0;
            verify_q      <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        error     <= 1'b0;
                        err_count <= 8'h00;
                        timeout   <= 1'b0;
                        cur_index <= '0;
                        tbl_addr  <= '0;
                        verify_q  <= verify_en;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    tbl_addr <= cur_index;
                    state    <= S_DECODE;
                end
                S_DECODE: begin
                    if (tbl_data == 16'hFFFF) begin
                        state <= S_FINISH;
                    end else if (tbl_data[15:8] == 8'hFE) begin
                        dly_cnt <= DLY_W'(tbl_data[7:0]) * DLY_W'(CYC_PER_MS);
                        state   <= S_DLY;
                    end else begin
                        sccb_sub_addr <= tbl_data[15:8];
                        sccb_data_in  <= tbl_data[7:0];
                        sccb_rw       <= 1'b0;
                        to_cnt        <= '0;
                        state         <= S_REQ;
                    end
                end
                // start rises one cycle after the transaction fields settle
                S_REQ: begin
                    if (done_p1) begin
                        sccb_start <= 1'b0;
                        if (sccb_rw) rd_data <= sccb_data_out;
                        to_cnt <= '0;
                        state  <= S_ACK;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC)) begin
                        sccb_start <= 1'b0;
                        error      <= 1'b1;
                        timeout    <= 1'b1;
                        busy       <= 1'b0;
                        seq_done   <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        sccb_start <= 1'b1;
                        to_cnt     <= to_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (!done_p1) begin
                        if (sccb_rw) begin
                            state <= S_CHECK;
                        end else if (verify_q) begin
                            sccb_rw <= 1'b1;
                            to_cnt  <= '0;
                            state   <= S_REQ;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC)) begin
                        error    <= 1'b1;
                        timeout  <= 1'b1;
                        busy     <= 1'b0;
                        seq_done <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (rd_data != sccb_data_in) begin
                        err_count <= sat_inc8(err_count);
                        error     <= 1'b1;
                    end
                    state <= S_NEXT;
                end
                S_DLY: begin
                    if (dly_cnt == '0) state <= S_NEXT;
                    else dly_cnt <= dly_cnt - 1'b1;
                end
                // the last table slot ends the run rather than wrapping to entry 0
                S_NEXT: begin
                    if (cur_index == LAST_IDX) begin
                        state <= S_FINISH;
                    end else begin
                        cur_index <= cur_index + 1'b1;
                        tbl_addr  <= cur_index + 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    seq_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer with a cycle-based CoreSCCB responder and table ROM.
module tb_sccb_init_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       verify_en = 1'b0;
    logic [1:0] tbl_addr;
    logic [15:0] tbl_data = 16'h0000;
    logic       sccb_start, sccb_rw;
    logic [6:0] sccb_ip_addr;
    logic [7:0] sccb_sub_addr, sccb_data_in;
    logic [7:0] sccb_data_out = 8'h00;
    logic       sccb_done = 1'b0;
    logic       busy, seq_done, error, timeout;
    logic [7:0] err_count;
    logic [1:0] cur_index;

    int checks = 0;
    int errors = 0;

    logic [15:0] tbl [4];
    logic [7:0]  rd_vals [4];
    int          rd_idx = 0;
    bit          resp_en = 1'b1;
    logic [16:0] txn_log [16];
    int          txn_gap [16];
    int          n_txn = 0;
    logic [16:0] cur_txn;
    int          m_st = 0, m_cnt = 0, low_run = 0, gap_last = 0;
    logic        start_prev = 1'b0;

    sccb_init_sequencer #(
        .TBL_AW(2), .DEV_ADDR(7'h21), .CYC_PER_MS(10), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .resetn(resetn), .go(go), .verify_en(verify_en),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .sccb_start(sccb_start), .sccb_rw(sccb_rw), .sccb_ip_addr(sccb_ip_addr),
        .sccb_sub_addr(sccb_sub_addr), .sccb_data_in(sccb_data_in),
        .sccb_data_out(sccb_data_out), .sccb_done(sccb_done),
        .busy(busy), .seq_done(seq_done), .error(error), .err_count(err_count),
        .timeout(timeout), .cur_index(cur_index)
    );

    always #5 clk = ~clk;

    // Table ROM (one cycle read latency) and CoreSCCB responder
    initial begin
        forever begin
            @(posedge clk); #1;
            tbl_data = tbl[tbl_addr];
            if (!resetn) begin
                m_st = 0; sccb_done = 1'b0; low_run = 0; start_prev = 1'b0;
            end else begin
                if (sccb_start && !start_prev) gap_last = low_run;
                if (sccb_start) low_run = 0; else low_run++;
                start_prev = sccb_start;
                case (m_st)
                    0: if (sccb_start && resp_en) begin
                        cur_txn = {sccb_rw, sccb_sub_addr, sccb_data_in};
                        if (n_txn < 16) begin
                            txn_log[n_txn] = cur_txn;
                            txn_gap[n_txn] = gap_last;
                        end
                        n_txn++;
                        m_cnt = 0;
                        m_st = 1;
                    end
                    1: begin
                        m_cnt++;
                        if (m_cnt == 3) begin
                            checks++;
                            if ({sccb_rw, sccb_sub_addr, sccb_data_in} !== cur_txn) begin
                                errors++;
                                $display("FAIL txn_stable: got %h want %h",
                                         {sccb_rw, sccb_sub_addr, sccb_data_in}, cur_txn);
                            end
                            if (sccb_rw) begin
                                sccb_data_out = rd_vals[rd_idx & 3];
                                rd_idx++;
                            end
                            sccb_done = 1'b1;
                            m_st = 2;
                        end
                    end
                    default: if (!sccb_start) begin
                        sccb_done = 1'b0;
                        m_st = 0;
                    end
                endcase
            end
        end
    end

    task automatic pulse_go(input logic ven);
        @(posedge clk); #1;
        verify_en = ven;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_seq_done(input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            if (seq_done) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic start_run(input logic ven);
        n_txn = 0;
        rd_idx = 0;
        pulse_go(ven);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sccb_start, busy, seq_done, error, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {sccb_start, busy, seq_done, error, timeout});
        end
        checks++;
        if ({err_count, cur_index, tbl_addr} !== 12'h000) begin
            errors++;
            $display("FAIL reset_regs: got %h want 000", {err_count, cur_index, tbl_addr});
        end
        checks++;
        if (sccb_ip_addr !== 7'h21) begin
            errors++;
            $display("FAIL ip_addr: got %h want 21", sccb_ip_addr);
        end
        resetn = 1'b1;
    endtask

    task automatic test_write_seq;
        bit seen;
        tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'hFFFF; tbl[3] = 16'h0000;
        start_run(1'b0);
        wait_seq_done(500, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL write_done: got no seq_done want pulse"); end
        checks++;
        if (n_txn !== 2) begin errors++; $display("FAIL write_count: got %0d want 2", n_txn); end
        checks++;
        if (txn_log[0] !== 17'h01280 || txn_log[1] !== 17'h01101) begin
            errors++;
            $display("FAIL write_txns: got %h %h want 01280 01101", txn_log[0], txn_log[1]);
        end
        checks++;
        if ({busy, error, timeout, err_count} !== 11'h000 || cur_index !== 2'd2) begin
            errors++;
            $display("FAIL write_status: got busy=%b err=%b to=%b cnt=%0d idx=%0d want 0 0 0 0 2",
                     busy, error, timeout, err_count, cur_index);
        end
        @(posedge clk); #1;
        checks++;
        if (seq_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", seq_done); end
    endtask

    task automatic test_verify;
        bit seen;
        tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'hFFFF; tbl[3] = 16'h0000;
        rd_vals[0] = 8'h80; rd_vals[1] = 8'h00;
        start_run(1'b1);
        wait_seq_done(800, seen);
        checks++;
        if (!seen || n_txn !== 4) begin
            errors++;
            $display("FAIL verify_count: got seen=%b n=%0d want 1 4", seen, n_txn);
        end
        checks++;
        if (txn_log[0] !== 17'h01280 || txn_log[1] !== 17'h11280 ||
            txn_log[2] !== 17'h01101 || txn_log[3] !== 17'h11101) begin
            errors++;
            $display("FAIL verify_txns: got %h %h %h %h want 01280 11280 01101 11101",
                     txn_log[0], txn_log[1], txn_log[2], txn_log[3]);
        end
        checks++;
        if (err_count !== 8'd1 || error !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL verify_err: got cnt=%0d err=%b to=%b want 1 1 0", err_count, error, timeout);
        end
    endtask

    task automatic test_delay;
        bit seen;
        tbl[0] = 16'h1280; tbl[1] = 16'hFE02; tbl[2] = 16'h1101; tbl[3] = 16'hFFFF;
        start_run(1'b0);
        wait_seq_done(800, seen);
        checks++;
        if (!seen || n_txn !== 2 || error !== 1'b0) begin
            errors++;
            $display("FAIL delay_run: got seen=%b n=%0d err=%b want 1 2 0", seen, n_txn, error);
        end
        checks++;
        if (txn_gap[1] < 20) begin
            errors++;
            $display("FAIL delay_gap: got %0d want >=20", txn_gap[1]);
        end
        checks++;
        if (cur_index !== 2'd3) begin errors++; $display("FAIL delay_idx: got %0d want 3", cur_index); end
    endtask

    task automatic test_timeout;
        int hi;
        bit rose;
        tbl[0] = 16'h1280; tbl[1] = 16'hFFFF; tbl[2] = 16'h0000; tbl[3] = 16'h0000;
        resp_en = 1'b0;
        start_run(1'b0);
        rose = 1'b0;
        for (int i = 0; i < 20 && !rose; i++) begin
            @(posedge clk); #1;
            if (sccb_start) rose = 1'b1;
        end
        hi = rose ? 1 : 0;
        while (rose && hi < 300) begin
            @(posedge clk); #1;
            if (sccb_start) hi++; else break;
        end
        checks++;
        if (hi !== 100) begin errors++; $display("FAIL timeout_len: got %0d want 100", hi); end
        checks++;
        if ({seq_done, timeout, error, busy} !== 4'b1110) begin
            errors++;
            $display("FAIL timeout_flags: got %b want 1110", {seq_done, timeout, error, busy});
        end
        @(posedge clk); #1;
        checks++;
        if (seq_done !== 1'b0 || sccb_start !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: got done=%b start=%b want 0 0", seq_done, sccb_start);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        bit seen;
        bit rose;
        tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'hFFFF; tbl[3] = 16'h0000;
        resp_en = 1'b0;
        start_run(1'b0);
        rose = 1'b0;
        for (int i = 0; i < 20 && !rose; i++) begin
            @(posedge clk); #1;
            if (sccb_start) rose = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (!rose || {sccb_start, busy, error, timeout, seq_done} !== 5'b0 || err_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: got rose=%b start=%b busy=%b err=%b to=%b cnt=%0d want 1 0 0 0 0 0",
                     rose, sccb_start, busy, error, timeout, err_count);
        end
        resetn = 1'b1;
        resp_en = 1'b1;
        start_run(1'b0);
        wait_seq_done(500, seen);
        checks++;
        if (!seen || n_txn !== 2 || txn_log[0] !== 17'h01280) begin
            errors++;
            $display("FAIL reset_rerun: got seen=%b n=%0d first=%h want 1 2 01280", seen, n_txn, txn_log[0]);
        end
    endtask

    task automatic test_no_end;
        bit seen;
        tbl[0] = 16'h0101; tbl[1] = 16'h0202; tbl[2] = 16'h0303; tbl[3] = 16'h0404;
        start_run(1'b0);
        repeat (10) @(posedge clk);
        #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        wait_seq_done(1000, seen);
        checks++;
        if (!seen || n_txn !== 4) begin
            errors++;
            $display("FAIL noend_count: got seen=%b n=%0d want 1 4", seen, n_txn);
        end
        checks++;
        if (txn_log[0] !== 17'h00101 || txn_log[1] !== 17'h00202 ||
            txn_log[2] !== 17'h00303 || txn_log[3] !== 17'h00404) begin
            errors++;
            $display("FAIL noend_txns: got %h %h %h %h want 00101 00202 00303 00404",
                     txn_log[0], txn_log[1], txn_log[2], txn_log[3]);
        end
        checks++;
        if (cur_index !== 2'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL noend_idx: got idx=%0d busy=%b want 3 0", cur_index, busy);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (n_txn !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL noend_wrap: got n=%0d busy=%b want 4 0", n_txn, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tbl[i] = 16'h0000;
            rd_vals[i] = 8'h00;
        end
        test_reset();
        test_write_seq();
        test_verify();
        test_delay();
        test_timeout();
        test_reset_mid();
        test_no_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
